// File: rtl/mem_copy_if.sv
// Data-memory port shared between the copy engine (master) and the memory
// (slave). The memory answers reads combinationally in the same cycle and
// commits writes on the rising clock edge.
//   address    : byte address, driven by master
//   data_write : write data, driven by master
//   mem_write  : write enable, driven by master
//   mem_read   : read enable, driven by master
//   data_read  : read data, driven by slave
interface mem_copy_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
);
    logic [ADDR_W-1:0] address;
    logic [DATA_W-1:0] data_write;
    logic              mem_write;
    logic              mem_read;
    logic [DATA_W-1:0] data_read;

    modport master (output address, data_write, mem_write, mem_read, input  data_read);
    modport slave  (input  address, data_write, mem_write, mem_read, output data_read);
endinterface

// File: rtl/mem_copy_engine.sv
// Block copy engine: copies `count` 16-bit words from src_addr to dst_addr in
// the same data memory, one word every two cycles (READ then WRITE), and keeps
// a running mod-2^16 sum of the words read.
//   clk, rst_n           : clock, asynchronous active-low reset
//   start, abort         : launch (IDLE only) / cancel an in-progress copy
//   src_addr, dst_addr   : byte addresses, bit 0 dropped on capture
//   count                : words to copy, 0 allowed
//   busy, done, aborted  : status (busy in READ/WRITE, one-cycle pulses)
//   checksum, words_left : running sum of words read, words not yet written
//   bus                  : data-memory master port
module mem_copy_engine #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W-1:0] src_addr,
    input  logic [ADDR_W-1:0] dst_addr,
    input  logic [ADDR_W-1:0] count,
    output logic              busy,
    output logic              done,
    output logic              aborted,
    output logic [DATA_W-1:0] checksum,
    output logic [ADDR_W-1:0] words_left,
    mem_copy_if.master        bus
);
    typedef enum logic [1:0] {IDLE, READ, WRITE, FIN} state_t;

    state_t            state;
    logic [ADDR_W-1:0] src_r, dst_r, left_r;
    logic [DATA_W-1:0] buf_r, sum_r;
    logic              aborted_r;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            src_r     <= '0;
            dst_r     <= '0;
            left_r    <= '0;
            buf_r     <= '0;
            sum_r     <= '0;
            aborted_r <= 1'b0;
        end else begin
            aborted_r <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    src_r  <= {src_addr[ADDR_W-1:1], 1'b0};
                    dst_r  <= {dst_addr[ADDR_W-1:1], 1'b0};
                    left_r <= count;
                    sum_r  <= '0;
                    state  <= (count == '0) ? FIN : READ;
                end
                READ: if (abort) begin
                    // Nothing captured; the word in flight is simply dropped.
                    state     <= IDLE;
                    aborted_r <= 1'b1;
                end else begin
                    buf_r <= bus.data_read;
                    sum_r <= sum_r + bus.data_read;
                    src_r <= src_r + ADDR_W'(2);
                    state <= WRITE;
                end
                WRITE: begin
                    // The memory samples mem_write on this same edge, so the
                    // write lands even when abort is asserted; book-keep it.
                    dst_r  <= dst_r + ADDR_W'(2);
                    left_r <= left_r - ADDR_W'(1);
                    if (abort) begin
                        state     <= IDLE;
                        aborted_r <= 1'b1;
                    end else begin
                        state <= (left_r == ADDR_W'(1)) ? FIN : READ;
                    end
                end
                FIN:     state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Bus controls decode straight from the state register and registered
    // address/buffer, so async reset forces them low immediately.
    assign busy           = (state == READ) || (state == WRITE);
    assign done           = (state == FIN);
    assign aborted        = aborted_r;
    assign checksum       = sum_r;
    assign words_left     = left_r;
    assign bus.mem_read   = (state == READ);
    assign bus.mem_write  = (state == WRITE);
    assign bus.address    = (state == READ)  ? src_r :
                            (state == WRITE) ? dst_r : '0;
    assign bus.data_write = (state == WRITE) ? buf_r : '0;
endmodule
